// File: rtl/adder_result_serializer.sv
// Buffers {carry, sum} words from the adder in a small FIFO and sends each one
// as a serial frame: start bit, data LSB first, even parity, stop bit.
module adder_result_serializer #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 5,
    parameter int BAUD_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [3:0]               carry_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg,    state_next;
    logic [BW-1:0]     baud_reg,     baud_next;
    logic [CW-1:0]     bit_reg,      bit_next;
    logic [DATA_W-1:0] shift_reg,    shift_next;
    logic              parity_reg,   parity_next;
    logic              tx_reg,       tx_next;
    logic              busy_reg,     busy_next;
    logic [PW-1:0]     wr_ptr_reg,   wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg,   rd_ptr_next;
    logic [LW-1:0]     level_reg,    level_next;
    logic              in_ready_reg, in_ready_next;
    logic [3:0]        carry_reg,    carry_next;

    logic push;
    logic pop;
    logic bit_end;

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        carry_next    = carry_reg;
        level_next    = level_reg;
        tx_next       = 1'b1;
        busy_next     = 1'b0;
        in_ready_next = 1'b1;
        pop           = 1'b0;

        push    = in_valid && in_ready_reg;
        bit_end = (baud_reg == BW'(BAUD_DIV - 1));

        if (state_reg != IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (level_reg != '0) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == CW'(DATA_W - 1)) begin
                        state_next = PARITY;
                    end else begin
                        shift_next = shift_reg >> 1;
                        bit_next   = bit_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Last stop cycle chains straight into the next frame if one is waiting.
                if (bit_end) begin
                    if (level_reg != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (pop) begin
            shift_next  = mem[rd_ptr_reg];
            parity_next = ^mem[rd_ptr_reg];
            state_next  = START;
            baud_next   = '0;
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (in_data[DATA_W-1] && (carry_reg != 4'd15)) begin
                carry_next = carry_reg + 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        // Line and flags are registered off the next state so they change with it.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
        busy_next     = (state_next != IDLE);
        in_ready_next = (level_next != LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            in_ready_reg <= 1'b1;
            carry_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            in_ready_reg <= in_ready_next;
            carry_reg    <= carry_next;
        end
    end

    assign tx        = tx_reg;
    assign busy      = busy_reg;
    assign level     = level_reg;
    assign in_ready  = in_ready_reg;
    assign carry_cnt = carry_reg;

endmodule

// File: tb/tb_adder_result_serializer.sv
// Bench for adder_result_serializer: queue-and-frame reference model checked every
// cycle, plus directed scenarios with hand-derived expectations.
module tb_adder_result_serializer;

    localparam int DEPTH    = 4;
    localparam int DATA_W   = 5;
    localparam int BAUD_DIV = 4;
    localparam int FRAME    = (DATA_W + 3) * BAUD_DIV;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              tx;
    logic              busy;
    logic [2:0]        level;
    logic [3:0]        carry_cnt;

    int tests;
    int fails;

    adder_result_serializer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy), .level(level),
        .carry_cnt(carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending words and the frame currently on the line.
    logic [DATA_W-1:0] mq[$];
    bit                m_active;
    int                m_t;
    logic              m_bits [DATA_W+3];
    int                m_carry;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_t      = 0;
            m_carry  = 0;
        end else begin
            int          sz;
            bit          acc;
            bit          pop;
            logic [DATA_W-1:0] w;
            logic [DATA_W-1:0] din;
            din = in_data;
            sz  = mq.size();
            acc = in_valid && (sz < DEPTH);
            pop = (sz > 0) && (!m_active || m_t == FRAME - 1);
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 0;
            end
            if (pop) begin
                w = mq.pop_front();
                m_bits[0] = 1'b0;
                for (int k = 0; k < DATA_W; k++) m_bits[k+1] = w[k];
                m_bits[DATA_W+1] = logic'($countones(w) % 2);
                m_bits[DATA_W+2] = 1'b1;
                m_active = 1;
                m_t      = 0;
            end
            if (acc) begin
                mq.push_back(din);
                if (din[DATA_W-1] && m_carry < 15) m_carry++;
            end
            #1;
            chk("model_tx", tx, m_active ? m_bits[m_t / BAUD_DIV] : 1'b1);
            chk("model_busy", busy, m_active);
            chk("model_level", level, mq.size());
            chk("model_in_ready", in_ready, mq.size() != DEPTH);
            chk("model_carry_cnt", carry_cnt, m_carry);
        end
    end

    // Called at a negedge; holds the word until in_ready, returns at the negedge after acceptance.
    task automatic push(input logic [DATA_W-1:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("push_accepted_in_time", n < 2000, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || level !== 3'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (busy === 1'b0 && level === 3'd0), 1);
        @(negedge clk);
    endtask

    initial begin
        int lit [8];
        logic cap [64];
        bit   hold;
        bit   r;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_level", level, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_carry_cnt", carry_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word 10110: start, 0,1,1,0,1, parity 1, stop.
        lit = '{0, 0, 1, 1, 0, 1, 1, 1};
        push(5'b10110);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("single_tx", tx, lit[i / BAUD_DIV]);
            chk("single_busy", busy, 1);
        end
        @(negedge clk);
        chk("single_busy_end", busy, 0);
        chk("single_carry_cnt", carry_cnt, 1);
        wait_idle();

        // Fill: first word popped at once, next four fill the FIFO.
        for (int i = 1; i <= 5; i++) push(DATA_W'(i));
        chk("fill_level", level, 4);
        chk("fill_in_ready", in_ready, 0);
        push(5'h06);
        wait_idle();

        // Push on the last stop-bit edge with level 1.
        push(5'h0A);
        push(5'h0B);
        repeat (31) @(negedge clk);
        push(5'h0C);
        chk("simul_level", level, 1);
        chk("simul_busy", busy, 1);
        chk("simul_tx_start", tx, 0);
        wait_idle();

        // Carry saturation.
        repeat (17) push(5'b10000);
        chk("carry_sat", carry_cnt, 15);
        push(5'h0F);
        chk("carry_hold", carry_cnt, 15);
        wait_idle();

        // Parity of all-zero and all-one words.
        push(5'b00000);
        push(5'b11111);
        cap[0] = tx;
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            cap[c] = tx;
        end
        chk("parity_zero", cap[6*BAUD_DIV+1], 0);
        chk("stop_zero", cap[7*BAUD_DIV+1], 1);
        chk("parity_ones", cap[FRAME+6*BAUD_DIV+1], 1);
        chk("stop_ones", cap[FRAME+7*BAUD_DIV+1], 1);
        wait_idle();

        // Reset during data bit 2 (a zero bit) with words still buffered.
        push(5'h11);
        push(5'h16);
        push(5'h17);
        repeat (11) @(negedge clk);
        chk("pre_reset_tx", tx, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_level", level, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_carry_cnt", carry_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(5'h13);
        wait_idle();

        // Randomized bursty traffic with upstream holding words while stalled.
        for (int i = 0; i < 2000; i++) begin
            r = in_ready;
            if (!in_valid && ($urandom_range(0, 99) < ((i / 200) % 2 ? 70 : 8))) begin
                in_valid = 1'b1;
                in_data  = DATA_W'($urandom);
            end
            hold = in_valid && r;
            @(negedge clk);
            if (hold) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
